seven_seg_driver: RTL and testbench
===================================

SEVEN_SEG_DRIVER -- requirements
Module: seven_seg_driver

Interface
REQ-001 The block SHALL have parameter ACTIVE_LOW, default 1, meaning 1 = anode/cathode/dp outputs active-low and 0 = active-high.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 digit_sel  input  3  digit index from the upstream refresh counter; nominally increments 0..7 and wraps.
REQ-005 data_in  input  32  eight hex nibbles; nibble k (bits 4k+3:4k) SHALL be shown on digit k.
REQ-006 dp_in  input  8  decimal-point enables, bit k for digit k.
REQ-007 load  input  1  single-cycle strobe requesting capture of data_in/dp_in.
REQ-008 busy  output  1  high while a captured value awaits display commit.
REQ-009 anode  output  8  one-hot digit enable, polarity per ACTIVE_LOW.
REQ-010 cathode  output  7  segments: bit 0 = a through bit 6 = g, polarity per ACTIVE_LOW.
REQ-011 dp  output  1  decimal point for the active digit, polarity per ACTIVE_LOW.

Function
REQ-012 A load with busy=0 SHALL capture data_in and dp_in into a pending register and set busy in the following cycle.
REQ-013 A load with busy=1 SHALL be ignored; the pending register SHALL not change.
REQ-014 The block SHALL register digit_sel each cycle as prev_sel.
REQ-015 A frame boundary SHALL be the cycle where prev_sel=7 and digit_sel=0.
REQ-016 On a frame boundary with busy=1, the shadow register SHALL take the pending value and busy SHALL clear, both visible the next cycle.
REQ-017 Load and frame boundary in the same cycle with busy=1: commit proceeds and load is ignored.
REQ-018 Non-sequential digit_sel jumps SHALL cause no error; commit occurs only on the exact 7->0 transition.
REQ-019 anode, cathode and dp SHALL be registered, with one-cycle latency from digit_sel.
REQ-020 Exactly one anode bit, bit digit_sel, SHALL be asserted per cycle outside reset.
REQ-021 cathode SHALL be the hex decode of shadow nibble digit_sel, active-high pattern g..a:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
REQ-022 With ACTIVE_LOW=1, outputs SHALL be the bitwise inverse of the active-high patterns.
REQ-023 dp SHALL reflect shadow dp bit digit_sel.

Reset
REQ-024 Reset SHALL clear shadow, pending, busy and prev_sel to 0.
REQ-025 Reset SHALL drive anode, cathode and dp to deasserted: 8'hFF/7'h7F/1 when ACTIVE_LOW=1, or 0 when ACTIVE_LOW=0.
REQ-026 Reset asserted while busy=1 SHALL discard the pending value; no commit occurs afterwards.
REQ-027 Reset SHALL take priority over load and commit in the same cycle.

Configuration
REQ-028 With macro SEVSEG_LZB_EN defined, digit k>0 SHALL be blanked when shadow nibbles k..7 are all zero; digit 0 is never blanked.
REQ-029 A blanked digit SHALL keep its anode asserted and drive cathode and dp deasserted.
REQ-030 Without SEVSEG_LZB_EN, no blanking logic SHALL exist and every digit SHALL show its nibble.

Verification
REQ-031 Reset, then sweep digit_sel 0..7 -> one cycle later anode=~(1<<k); with shadow=0, cathode=~7'h3F each digit (ACTIVE_LOW=1).
REQ-032 load data_in=32'h89ABCDEF, dp_in=8'h01 mid-frame -> busy=1 the next cycle; display stays at old value until 7->0; then digit 0 cathode=~7'h71 with dp asserted, digit 7 cathode=~7'h7F, and busy=0.
REQ-033 With busy=1, load 32'h11111111 -> ignored; after commit, the first captured value is shown.
REQ-034 load 32'h12345678, then reset before the frame boundary -> busy=0, shadow=0, all outputs deasserted for the reset cycle, and no later commit of 12345678.
REQ-035 SEVSEG_LZB_EN defined, commit 32'h00000A05 -> digits 3..7 cathode=7'h7F (off), digit 2 = ~7'h77, digit 1 = ~7'h3F, digit 0 = ~7'h6D; commit 0 -> only digit 0 shows "0".
REQ-036 digit_sel sequence 7,3,0 -> no commit while busy=1; the next genuine 7->0 commits.

Source files
------------

// File: rtl/seven_seg_driver.sv
// Eight-digit multiplexed hex seven-segment driver with pending/shadow double buffering.
// Optional leading-zero blanking is compiled in with macro SEVSEG_LZB_EN.
module seven_seg_driver #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  digit_sel,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic        busy,
  output logic [7:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp
);

  localparam logic INV = (ACTIVE_LOW != 0);

  logic [2:0]  prev_sel;
  logic [31:0] pend_data, shadow_data, disp_data;
  logic [7:0]  pend_dp, shadow_dp, disp_dp;
  logic        commit;
  logic [3:0]  nibble;
  logic [7:0]  an_hi;
  logic [6:0]  seg_hi;
  logic        dp_hi;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign commit = busy && (prev_sel == 3'd7) && (digit_sel == 3'd0);

  // Decode from the value the shadow holds next cycle, so digit 0 of the
  // new frame already shows freshly committed data.
  assign disp_data = commit ? pend_data : shadow_data;
  assign disp_dp   = commit ? pend_dp   : shadow_dp;

`ifdef SEVSEG_LZB_EN
  logic [7:0] blank;
  logic       zero_above;

  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned i = 7; i >= 1; i--) begin
      zero_above = zero_above && (disp_data[4*i +: 4] == 4'h0);
      blank[i]   = zero_above;
    end
  end
`endif

  always_comb begin
    nibble = disp_data[{digit_sel, 2'b00} +: 4];
    an_hi  = 8'd1 << digit_sel;
    seg_hi = hex7(nibble);
    dp_hi  = disp_dp[digit_sel];
`ifdef SEVSEG_LZB_EN
    if (blank[digit_sel]) begin
      seg_hi = '0;
      dp_hi  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sel    <= '0;
      pend_data   <= '0;
      pend_dp     <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      busy        <= 1'b0;
      anode       <= {8{INV}};
      cathode     <= {7{INV}};
      dp          <= INV;
    end else begin
      prev_sel <= digit_sel;
      if (commit) begin
        shadow_data <= pend_data;
        shadow_dp   <= pend_dp;
        busy        <= 1'b0;
      end else if (load && !busy) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        busy      <= 1'b1;
      end
      anode   <= an_hi  ^ {8{INV}};
      cathode <= seg_hi ^ {7{INV}};
      dp      <= dp_hi  ^ INV;
    end
  end

endmodule

// File: tb/tb_seven_seg_driver.sv
// Directed self-checking bench for seven_seg_driver (ACTIVE_LOW=1); honours SEVSEG_LZB_EN.
module tb_seven_seg_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  digit_sel;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        load;
  logic        busy;
  logic [7:0]  anode;
  logic [6:0]  cathode;
  logic        dp;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  seven_seg_driver #(.ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .digit_sel(digit_sel), .data_in(data_in),
    .dp_in(dp_in), .load(load), .busy(busy), .anode(anode),
    .cathode(cathode), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; results are sampled at the next falling edge.
  task automatic cyc(input logic [2:0] s);
    digit_sel = s;
    load      = 1'b0;
    @(negedge clk);
  endtask

  task automatic cycl(input logic [2:0] s, input logic [31:0] d, input logic [7:0] p);
    digit_sel = s;
    load      = 1'b1;
    data_in   = d;
    dp_in     = p;
    @(negedge clk);
  endtask

  task automatic chk_digit(input string tag, input int k, input logic [6:0] seg_hi, input logic dp_hi);
    logic [7:0] a;
    a = 8'd1 << k;
    chk({tag, "_anode"}, {24'd0, anode}, {24'd0, ~a});
    chk({tag, "_cath"}, {25'd0, cathode}, {25'd0, ~seg_hi});
    chk({tag, "_dp"}, {31'd0, dp}, {31'd0, ~dp_hi});
  endtask

  logic [6:0] frame_a [8];
`ifdef SEVSEG_LZB_EN
  localparam logic [6:0] ZERO_HI = 7'h00;
`else
  localparam logic [6:0] ZERO_HI = 7'h3F;
`endif

  initial begin
    frame_a = '{7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F};
    reset = 1'b1; digit_sel = '0; data_in = '0; dp_in = '0; load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_anode", {24'd0, anode}, 32'hFF);
    chk("rst_cath", {25'd0, cathode}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'h1);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    reset = 1'b0;

    // Blank shadow: digit 0 shows "0"; higher digits show "0" or are blanked
    for (int k = 0; k < 8; k++) begin
      cyc(3'(k));
      chk_digit("sweep0", k, (k == 0) ? 7'h3F : ZERO_HI, 1'b0);
    end

    // Load mid-frame; a second load while busy is ignored
    cyc(3'd0);
    cyc(3'd1);
    cycl(3'd2, 32'h89ABCDEF, 8'h01);
    chk("busy_set", {31'd0, busy}, 32'h1);
    cyc(3'd3);
    chk_digit("old_d3", 3, ZERO_HI, 1'b0);
    cycl(3'd4, 32'h11111111, 8'hFF);
    cyc(3'd5);
    cyc(3'd6);
    cyc(3'd7);
    chk("busy_hold", {31'd0, busy}, 32'h1);
    chk_digit("old_d7", 7, ZERO_HI, 1'b0);
    // Load coinciding with commit is ignored
    cycl(3'd0, 32'h11111111, 8'hFF);
    chk("busy_clr", {31'd0, busy}, 32'h0);
    chk_digit("new_d0", 0, 7'h71, 1'b1);
    for (int k = 1; k < 8; k++) begin
      cyc(3'(k));
      chk_digit("new_frame", k, frame_a[k], 1'b0);
    end
    chk("busy_stay", {31'd0, busy}, 32'h0);

    // Reset while busy discards pending; reset beats a simultaneous load
    cyc(3'd0);
    cycl(3'd1, 32'h12345678, 8'hFF);
    chk("busy_b4rst", {31'd0, busy}, 32'h1);
    reset = 1'b1;
    cycl(3'd2, 32'h12345678, 8'hFF);
    chk("rst2_anode", {24'd0, anode}, 32'hFF);
    chk("rst2_cath", {25'd0, cathode}, 32'h7F);
    chk("rst2_dp", {31'd0, dp}, 32'h1);
    chk("rst2_busy", {31'd0, busy}, 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) cyc(3'(k));
    cyc(3'd0);
    chk("rst2_nocommit_busy", {31'd0, busy}, 32'h0);
    chk_digit("rst2_d0", 0, 7'h3F, 1'b0);
    cyc(3'd1);
    chk_digit("rst2_d1", 1, ZERO_HI, 1'b0);

    // Non-sequential 7,3,0 must not commit; genuine 7->0 does
    cycl(3'd3, 32'h00000A05, 8'h02);
    cyc(3'd7);
    cyc(3'd3);
    cyc(3'd0);
    chk("jump_busy", {31'd0, busy}, 32'h1);
    chk_digit("jump_d0", 0, 7'h3F, 1'b0);
    cyc(3'd7);
    cyc(3'd0);
    chk("a05_busy", {31'd0, busy}, 32'h0);
    chk_digit("a05_d0", 0, 7'h6D, 1'b0);
    cyc(3'd1);
    chk_digit("a05_d1", 1, 7'h3F, 1'b1);
    cyc(3'd2);
    chk_digit("a05_d2", 2, 7'h77, 1'b0);
    cyc(3'd3);
    chk_digit("a05_d3", 3, ZERO_HI, 1'b0);
    cyc(3'd7);
    chk_digit("a05_d7", 7, ZERO_HI, 1'b0);

    // Commit all-zero value
    cycl(3'd1, 32'h00000000, 8'h00);
    cyc(3'd7);
    cyc(3'd0);
    chk("z_busy", {31'd0, busy}, 32'h0);
    chk_digit("z_d0", 0, 7'h3F, 1'b0);
    cyc(3'd1);
    chk_digit("z_d1", 1, ZERO_HI, 1'b0);
    cyc(3'd2);
    chk_digit("z_d2", 2, ZERO_HI, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
